// File: rtl/quick_spi_if.sv
// SPI pin bundle shared by the quick SPI master and responder.
interface quick_spi_if;
    logic sclk;
    logic ss_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output ss_n, output mosi, input miso);
    modport slave  (input sclk, input ss_n, input mosi, output miso);
endinterface

// File: rtl/quick_spi_slave.sv
// SPI responder: resynchronises the SPI pins into clk, receives one word on
// mosi while returning tx_data on miso, then ignores the master's trailing
// sclk toggles until ss_n rises.
module quick_spi_slave #(
    parameter int   DATA_WIDTH      = 8,
    parameter int   BITS_ORDER      = 1,
    parameter int   CPOL            = 0,
    parameter int   CPHA            = 0,
    parameter logic MISO_IDLE_VALUE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    quick_spi_if.slave            spi,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int               CNT_W          = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT     = CNT_W'(DATA_WIDTH);
    localparam logic             SCLK_IDLE      = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam bit               SAMPLE_ON_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       bit_count;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-1:0]  rx_shift;

    logic sclk_s1, sclk_s2, sclk_prev;
    logic ss_s1,   ss_s2,   ss_prev;
    logic mosi_s1, mosi_s2;

    logic [1:0] settle_cnt;
    logic       armed;

    logic sclk_rise, sclk_fall, sample_edge, shift_edge, ss_fall, ss_rise;

    // Bit of a tx word that goes out next on miso.
    function automatic logic tx_head(input logic [DATA_WIDTH-1:0] v);
        return (BITS_ORDER != 0) ? v[DATA_WIDTH-1] : v[0];
    endfunction

    // Drop the bit just presented so the following one becomes the head.
    function automatic logic [DATA_WIDTH-1:0] tx_advance(input logic [DATA_WIDTH-1:0] v);
        return (BITS_ORDER != 0) ? (v << 1) : (v >> 1);
    endfunction

    // Shift a received bit into the rx word from the side matching bit order.
    function automatic logic [DATA_WIDTH-1:0] rx_insert(input logic [DATA_WIDTH-1:0] v,
                                                        input logic b);
        logic [DATA_WIDTH-1:0] t;
        if (BITS_ORDER != 0) begin
            t = v << 1;
            t[0] = b;
        end else begin
            t = v >> 1;
            t[DATA_WIDTH-1] = b;
        end
        return t;
    endfunction

    // Two-flop synchronisers plus one previous-value stage for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_s1   <= SCLK_IDLE;
            sclk_s2   <= SCLK_IDLE;
            sclk_prev <= SCLK_IDLE;
            ss_s1     <= 1'b1;
            ss_s2     <= 1'b1;
            ss_prev   <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
        end else begin
            sclk_s1   <= spi.sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            ss_s1     <= spi.ss_n;
            ss_s2     <= ss_s1;
            ss_prev   <= ss_s2;
            mosi_s1   <= spi.mosi;
            mosi_s2   <= mosi_s1;
        end
    end

    assign sclk_rise   = sclk_s2 & ~sclk_prev;
    assign sclk_fall   = ~sclk_s2 & sclk_prev;
    assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
    assign ss_fall     = ~ss_s2 & ss_prev;
    assign ss_rise     = ss_s2 & ~ss_prev;

    // Frame starts are only accepted once ss_n has genuinely been seen high
    // after reset; the synchroniser reset value alone would otherwise fake a
    // falling edge when reset is released in the middle of a frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            settle_cnt <= 2'd0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != 2'd3)
                settle_cnt <= settle_cnt + 2'd1;
            else if (ss_s2)
                armed <= 1'b1;
        end
    end

    // Frame state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_count   <= '0;
            spi.miso    <= MISO_IDLE_VALUE;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    spi.miso <= MISO_IDLE_VALUE;
                    if (ss_fall && armed && enable) begin
                        bit_count <= '0;
                        busy      <= 1'b1;
                        state     <= ACTIVE;
                        if (CPHA == 0) begin
                            spi.miso <= tx_head(tx_data);
                            tx_shift <= tx_advance(tx_data);
                        end else begin
                            tx_shift <= tx_data;
                        end
                    end
                end
                ACTIVE: begin
                    if (bit_count == LAST_COUNT) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        spi.miso <= MISO_IDLE_VALUE;
                        if (ss_rise) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (ss_rise) begin
                        // ss_n wins over a coincident sclk edge; the error
                        // decision uses the count before that edge.
                        frame_error <= (bit_count != '0);
                        spi.miso    <= MISO_IDLE_VALUE;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift  <= rx_insert(rx_shift, mosi_s2);
                            bit_count <= bit_count + CNT_W'(1);
                        end
                        if (shift_edge) begin
                            spi.miso <= tx_head(tx_shift);
                            tx_shift <= tx_advance(tx_shift);
                        end
                    end
                end
                DRAIN: begin
                    spi.miso <= MISO_IDLE_VALUE;
                    if (ss_rise) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quick_spi_slave.sv
// Directed bench for quick_spi_slave: one mode-0 MSB-first instance and one
// mode-3 LSB-first instance, driven by a simple bit-banged SPI master.
module tb_quick_spi_slave;

    localparam int H = 8;  // sclk half period in clk cycles

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en0, en3;
    logic [7:0] tx0, tx3, rx0, rx3;
    logic       rxv0, rxv3, fe0, fe3, busy0, busy3;

    int n_cmp = 0;
    int n_bad = 0;
    int rxv_cnt0 = 0, fe_cnt0 = 0, rxv_cnt3 = 0, fe_cnt3 = 0;

    always #5 clk = ~clk;

    quick_spi_if if0 ();
    quick_spi_if if3 ();

    quick_spi_slave #(.DATA_WIDTH(8), .BITS_ORDER(1), .CPOL(0), .CPHA(0), .MISO_IDLE_VALUE(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(en0), .spi(if0.slave), .tx_data(tx0),
        .rx_data(rx0), .rx_valid(rxv0), .frame_error(fe0), .busy(busy0)
    );

    quick_spi_slave #(.DATA_WIDTH(8), .BITS_ORDER(0), .CPOL(1), .CPHA(1), .MISO_IDLE_VALUE(1'b0)) dut3 (
        .clk(clk), .reset_n(reset_n), .enable(en3), .spi(if3.slave), .tx_data(tx3),
        .rx_data(rx3), .rx_valid(rxv3), .frame_error(fe3), .busy(busy3)
    );

    // Pulse counters, sampled on the active edge (previous-cycle values).
    always @(posedge clk) begin
        if (rxv0) rxv_cnt0++;
        if (fe0)  fe_cnt0++;
        if (rxv3) rxv_cnt3++;
        if (fe3)  fe_cnt3++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_sclk(input int d, input logic v);
        if (d == 0) if0.sclk = v; else if3.sclk = v;
    endtask

    task automatic drive_ss(input int d, input logic v);
        if (d == 0) if0.ss_n = v; else if3.ss_n = v;
    endtask

    task automatic drive_mosi(input int d, input logic v);
        if (d == 0) if0.mosi = v; else if3.mosi = v;
    endtask

    function automatic logic get_miso(input int d);
        return (d == 0) ? if0.miso : if3.miso;
    endfunction

    // Clock bits first..first+count-1 of w; miso is captured into rd at the
    // master's sample point, at the same bit position as the outgoing bit.
    task automatic run_bits(input int d, input logic [7:0] w, input int first,
                            input int count, inout logic [7:0] rd);
        logic cpol, cpha, msb;
        int   idx;
        cpol = (d == 3);
        cpha = (d == 3);
        msb  = (d == 0);
        for (int i = first; i < first + count; i++) begin
            idx = msb ? 7 - i : i;
            if (!cpha) begin
                drive_mosi(d, w[idx]);
                tick(H);
                rd[idx] = get_miso(d);
                drive_sclk(d, ~cpol);
                tick(H);
                drive_sclk(d, cpol);
            end else begin
                drive_sclk(d, ~cpol);
                drive_mosi(d, w[idx]);
                tick(H);
                rd[idx] = get_miso(d);
                drive_sclk(d, cpol);
                tick(H);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        n_cmp++; if (rx0 !== 8'h00) begin n_bad++; $display("FAIL reset_rx0: got %h want 00", rx0); end
        n_cmp++; if ({rxv0, fe0, busy0} !== 3'b000) begin n_bad++; $display("FAIL reset_flags0: got %b want 000", {rxv0, fe0, busy0}); end
        n_cmp++; if (if0.miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso0: got %b want 0", if0.miso); end
        n_cmp++; if ({rx3, rxv3, fe3, busy3, if3.miso} !== 12'h000) begin n_bad++; $display("FAIL reset_dut3: got %h want 000", {rx3, rxv3, fe3, busy3, if3.miso}); end
        reset_n = 1'b1;
        tick(10);
    endtask

    task automatic test_mode0();
        logic [7:0] rd = 8'h00;
        int c = rxv_cnt0, f = fe_cnt0;
        tx0 = 8'h3C;
        drive_ss(0, 1'b0);
        tick(H);
        tx0 = 8'hFF;  // late change must not reach this frame
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL m0_busy_start: got %b want 1", busy0); end
        run_bits(0, 8'hA5, 0, 8, rd);
        tick(H);
        n_cmp++; if (rx0 !== 8'hA5) begin n_bad++; $display("FAIL m0_rx: got %h want a5", rx0); end
        n_cmp++; if (rd !== 8'h3C) begin n_bad++; $display("FAIL m0_miso: got %h want 3c", rd); end
        n_cmp++; if (rxv_cnt0 - c !== 1) begin n_bad++; $display("FAIL m0_rxv_count: got %0d want 1", rxv_cnt0 - c); end
        n_cmp++; if (fe_cnt0 - f !== 0) begin n_bad++; $display("FAIL m0_fe_count: got %0d want 0", fe_cnt0 - f); end
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL m0_busy_drain: got %b want 1", busy0); end
        drive_ss(0, 1'b1);
        tick(4);
        n_cmp++; if ({busy0, if0.miso} !== 2'b00) begin n_bad++; $display("FAIL m0_idle: got %b want 00", {busy0, if0.miso}); end
        tick(H);
    endtask

    task automatic test_frame_error();
        logic [7:0] rd = 8'h00;
        int c = rxv_cnt0, f = fe_cnt0;
        tx0 = 8'h00;
        drive_ss(0, 1'b0);
        tick(H);
        run_bits(0, 8'h3F, 0, 5, rd);
        tick(H);
        drive_ss(0, 1'b1);
        tick(6);
        n_cmp++; if (fe_cnt0 - f !== 1) begin n_bad++; $display("FAIL fe_count: got %0d want 1", fe_cnt0 - f); end
        n_cmp++; if (rxv_cnt0 - c !== 0) begin n_bad++; $display("FAIL fe_rxv_count: got %0d want 0", rxv_cnt0 - c); end
        n_cmp++; if (rx0 !== 8'hA5) begin n_bad++; $display("FAIL fe_rx_kept: got %h want a5", rx0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL fe_busy: got %b want 0", busy0); end
        tick(H);
    endtask

    task automatic test_extra_toggles();
        logic [7:0] rd = 8'h00;
        logic       s = 1'b0;
        int c = rxv_cnt0;
        tx0 = 8'h96;
        drive_ss(0, 1'b0);
        tick(H);
        run_bits(0, 8'hC3, 0, 8, rd);
        tick(H);
        for (int k = 0; k < 6; k++) begin
            s = ~s;
            drive_sclk(0, s);
            tick(4);
            n_cmp++; if (if0.miso !== 1'b0) begin n_bad++; $display("FAIL xt_miso_%0d: got %b want 0", k, if0.miso); end
            tick(4);
        end
        drive_ss(0, 1'b1);
        tick(2);
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL xt_busy_2clk: got %b want 1", busy0); end
        tick(1);
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL xt_busy_3clk: got %b want 0", busy0); end
        n_cmp++; if (rxv_cnt0 - c !== 1) begin n_bad++; $display("FAIL xt_rxv_count: got %0d want 1", rxv_cnt0 - c); end
        n_cmp++; if (rx0 !== 8'hC3) begin n_bad++; $display("FAIL xt_rx: got %h want c3", rx0); end
        n_cmp++; if (rd !== 8'h96) begin n_bad++; $display("FAIL xt_miso: got %h want 96", rd); end
        tick(H);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rd = 8'h00;
        int c, f;
        tx0 = 8'h0F;
        drive_ss(0, 1'b0);
        tick(H);
        run_bits(0, 8'hFF, 0, 3, rd);
        c = rxv_cnt0;
        f = fe_cnt0;
        reset_n = 1'b0;
        tick(1);
        n_cmp++; if (rx0 !== 8'h00) begin n_bad++; $display("FAIL rm_rx: got %h want 00", rx0); end
        n_cmp++; if ({rxv0, fe0, busy0, if0.miso} !== 4'b0000) begin n_bad++; $display("FAIL rm_flags: got %b want 0000", {rxv0, fe0, busy0, if0.miso}); end
        reset_n = 1'b1;
        run_bits(0, 8'hFF, 3, 5, rd);
        tick(H);
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL rm_busy_ignored: got %b want 0", busy0); end
        drive_ss(0, 1'b1);
        tick(H);
        n_cmp++; if ((rxv_cnt0 - c) + (fe_cnt0 - f) !== 0) begin n_bad++; $display("FAIL rm_pulses: got %0d want 0", (rxv_cnt0 - c) + (fe_cnt0 - f)); end
        drive_ss(0, 1'b0);
        tick(H);
        run_bits(0, 8'h5A, 0, 8, rd);
        tick(H);
        drive_ss(0, 1'b1);
        tick(H);
        n_cmp++; if (rx0 !== 8'h5A) begin n_bad++; $display("FAIL rm_rx_after: got %h want 5a", rx0); end
        n_cmp++; if (rd !== 8'h0F) begin n_bad++; $display("FAIL rm_miso_after: got %h want 0f", rd); end
    endtask

    task automatic test_mode3();
        logic [7:0] rd = 8'h00;
        int c = rxv_cnt3, f = fe_cnt3;
        tx3 = 8'h81;
        drive_ss(3, 1'b0);
        tick(H);
        run_bits(3, 8'h0F, 0, 8, rd);
        tick(H);
        n_cmp++; if (rx3 !== 8'h0F) begin n_bad++; $display("FAIL m3_rx: got %h want 0f", rx3); end
        n_cmp++; if (rd !== 8'h81) begin n_bad++; $display("FAIL m3_miso: got %h want 81", rd); end
        n_cmp++; if (rxv_cnt3 - c !== 1) begin n_bad++; $display("FAIL m3_rxv_count: got %0d want 1", rxv_cnt3 - c); end
        n_cmp++; if (fe_cnt3 - f !== 0) begin n_bad++; $display("FAIL m3_fe_count: got %0d want 0", fe_cnt3 - f); end
        drive_ss(3, 1'b1);
        tick(4);
        n_cmp++; if (busy3 !== 1'b0) begin n_bad++; $display("FAIL m3_busy_end: got %b want 0", busy3); end
        tick(H);
    endtask

    task automatic test_enable_low();
        logic [7:0] rd = 8'h00;
        int c = rxv_cnt0;
        tx0 = 8'hFF;
        en0 = 1'b0;
        drive_ss(0, 1'b0);
        tick(H);
        en0 = 1'b1;
        run_bits(0, 8'h77, 0, 8, rd);
        tick(H);
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL en_busy: got %b want 0", busy0); end
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL en_miso: got %h want 00", rd); end
        drive_ss(0, 1'b1);
        tick(H);
        n_cmp++; if (rxv_cnt0 - c !== 0) begin n_bad++; $display("FAIL en_rxv_count: got %0d want 0", rxv_cnt0 - c); end
        n_cmp++; if (rx0 !== 8'h5A) begin n_bad++; $display("FAIL en_rx_kept: got %h want 5a", rx0); end
    endtask

    initial begin
        reset_n  = 1'b0;
        en0      = 1'b1;
        en3      = 1'b1;
        tx0      = 8'h00;
        tx3      = 8'h00;
        if0.sclk = 1'b0;
        if0.ss_n = 1'b1;
        if0.mosi = 1'b0;
        if3.sclk = 1'b1;
        if3.ss_n = 1'b1;
        if3.mosi = 1'b0;
        test_reset();
        test_mode0();
        test_frame_error();
        test_extra_toggles();
        test_reset_midframe();
        test_mode3();
        test_enable_low();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
